// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a small byte FIFO.
// DATA register at BASE_ADDR (write pushes a byte), STATUS at BASE_ADDR+4.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing); default is 8N1.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic [2:0]        state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic [31:0]       read_data_q;

  logic        fifo_empty, fifo_full, bit_end;
  logic        push_req, push, pop, drop, ovf_clr;
  logic [2:0]  bit_idx_nxt;
  logic [31:0] status;
  logic        unused_ok;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  assign bit_end     = (baud_q == '0);
  assign bit_idx_nxt = bit_idx_q + 3'd1;

  // Head byte leaves the FIFO either from idle or straight out of a finishing stop bit.
  assign pop      = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign push_req = write_mem && (write_address == BASE_ADDR);
  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;
  assign ovf_clr  = write_mem && (write_address == STATUS_ADDR) && write_data[3];

  assign tx_busy   = (state_q != IDLE) || !fifo_empty;
  assign tx        = tx_q;
  assign read_data = read_data_q;

  // Store size and upper data bits carry no meaning for this peripheral.
  assign unused_ok = ^{funct3, write_data[31:8]};

  // STATUS register image.
  always_comb begin
    status      = '0;
    status[0]   = fifo_full;
    status[1]   = fifo_empty;
    status[2]   = tx_busy;
    status[3]   = overflow_q;
    status[8:4] = 5'(count_q);
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= write_data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Frame sequencer; tx is registered alongside the state so the line never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem[rd_ptr_q];
            baud_q  <= BAUD_RELOAD;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q    <= BAUD_RELOAD;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q    <= BAUD_RELOAD;
            bit_idx_q <= bit_idx_nxt;  // wraps 7 -> 0 on exit
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= ^shift_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              tx_q <= shift_q[bit_idx_nxt];
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_q  <= BAUD_RELOAD;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift_q <= mem[rd_ptr_q];
              baud_q  <= BAUD_RELOAD;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Registered load port: one cycle from address to data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= (read_address == STATUS_ADDR) ? status : 32'h0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed, table-driven bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity frame.
module tb_mmio_uart_tx;

  localparam int unsigned CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [31:0] STAT = 32'h0000_2004;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address, write_data, read_address;
  logic [31:0] read_data;
  logic        tx, tx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_mem    (write_mem),
    .funct3       (funct3),
    .write_address(write_address),
    .write_data   (write_data),
    .read_address (read_address),
    .read_data    (read_data),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;  // bit i = i-th bit on the wire
  } frame_vec_t;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
  } reg_vec_t;

  frame_vec_t fv[$];
  reg_vec_t   rv[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    write_mem     = 1'b1;
    write_address = addr;
    write_data    = data;
    funct3        = 3'($urandom_range(0, 7));
    tick();
    write_mem     = 1'b0;
  endtask

  // Expected wire level for bit slot b of a frame carrying d.
  function automatic logic line_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Bounded receiver: finds a start bit, samples mid-bit, ends mid-stop.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b  = '0;
    while (tx !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      ok = 1'b0;
      return;
    end
    repeat (2) tick();
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB) tick();
    if (tx !== ^b) ok = 1'b0;
`endif
    repeat (CPB) tick();
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rok;
    int         lows;
    int         n;

`ifdef UART_TX_PARITY_EN
    fv.push_back('{data: 8'h07, line: 11'b110_0000_1110});
    fv.push_back('{data: 8'h03, line: 11'b100_0000_0110});
    fv.push_back('{data: 8'hA5, line: 11'b101_0010_1010});
`else
    fv.push_back('{data: 8'hA5, line: 11'b011_0100_1010});
    fv.push_back('{data: 8'h55, line: 11'b010_1010_1010});
`endif
    rv.push_back('{"stat_idle",    1'b0, 32'h0,       32'h0,        STAT,          32'h2});
    rv.push_back('{"addr0",        1'b0, 32'h0,       32'h0,        32'h0,         32'h0});
    rv.push_back('{"data_reg_rd",  1'b0, 32'h0,       32'h0,        BASE,          32'h0});
    rv.push_back('{"other_wr",     1'b1, BASE + 8,    32'h41,       STAT,          32'h2});
    rv.push_back('{"after_other",  1'b0, 32'h0,       32'h0,        STAT,          32'h2});
    rv.push_back('{"stat_wr_ff",   1'b1, STAT,        32'hFF,       STAT,          32'h2});
    rv.push_back('{"after_statwr", 1'b0, 32'h0,       32'h0,        STAT,          32'h2});
    rv.push_back('{"far_addr",     1'b0, 32'h0,       32'h0,        BASE + 32'h1000, 32'h0});

    rst_n = 1'b0; write_mem = 1'b0; funct3 = '0;
    write_address = '0; write_data = '0; read_address = STAT;
    repeat (3) tick();
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_busy", 32'(tx_busy), 32'h0);
    check("reset_rdata", read_data, 32'h0);
    rst_n = 1'b1;

    // Register access vectors (all while idle and empty).
    foreach (rv[i]) begin
      write_mem     = rv[i].wr;
      write_address = rv[i].waddr;
      write_data    = rv[i].wdata;
      read_address  = rv[i].raddr;
      tick();
      write_mem     = 1'b0;
      check(rv[i].name, read_data, rv[i].exp_rd);
    end

    // Single frames: exact per-cycle line shape and one-cycle launch latency.
    foreach (fv[i]) begin
      store(BASE, {24'hFFFF_FF, fv[i].data});
      check("pre_launch_tx", 32'(tx), 32'h1);
      check("pre_launch_busy", 32'(tx_busy), 32'h1);
      tick();
      for (int t = 0; t < FRAME; t++) begin
        check("frame_bit", 32'(tx), 32'(fv[i].line[t / CPB]));
        tick();
      end
      check("frame_done_busy", 32'(tx_busy), 32'h0);
      check("frame_done_tx", 32'(tx), 32'h1);
    end

    // Nine back-to-back stores: first launches, eight queue, no gaps, no overflow.
    for (int k = 0; k < 9; k++) store(BASE, 32'(k));
    for (int t = 7; t < 9 * FRAME; t++) begin
      check("b2b_bit", 32'(tx), 32'(line_bit(8'(t / FRAME), (t % FRAME) / CPB)));
      tick();
    end
    check("b2b_done_busy", 32'(tx_busy), 32'h0);
    read_address = STAT;
    tick();
    check("b2b_status", read_data, 32'h2);

    // Overflow: fill during a frame, one extra store is dropped.
    store(BASE, 32'hFF);
    for (int k = 0; k < 8; k++) store(BASE, 32'h20 + 32'(k));
    store(BASE, 32'h99);
    tick();
    check("ovf_status", read_data, 32'h8D);
    store(STAT, 32'h8);
    tick();
    check("ovf_cleared", read_data, 32'h85);
    for (int k = 0; k < 8; k++) begin
      rx_byte(rb, rok);
      check("ovf_rx_ok", 32'(rok), 32'h1);
      check("ovf_rx_byte", 32'(rb), 32'h20 + 32'(k));
    end
    n = 0;
    while (tx_busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check("ovf_drain_busy", 32'(tx_busy), 32'h0);
    lows = 0;
    for (int t = 0; t < 2 * FRAME; t++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("ovf_no_dropped_frame", 32'(lows), 32'h0);

    // Reset mid-DATA aborts the frame.
    store(BASE, 32'h55);
    tick();
    repeat (CPB + 6) tick();
    check("mid_data_bit1", 32'(tx), 32'h0);
    rst_n = 1'b0;
    tick();
    check("abort_tx", 32'(tx), 32'h1);
    check("abort_busy", 32'(tx_busy), 32'h0);
    check("abort_rdata", read_data, 32'h0);
    rst_n = 1'b1;
    tick();
    check("abort_status", read_data, 32'h2);
    lows = 0;
    for (int t = 0; t < 2 * FRAME; t++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("abort_quiet", 32'(lows), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
